// File: rtl/sc_multichannel_timer_if.sv
// ---------------------------------------------------------------------------
// sc_multichannel_timer_if
//   Bundles the load bus, global enable and per-channel status of the
//   multi-channel timer so controller and timer connect through one port.
//
//   Signals
//     SC_TIMER_LOAD_InLow     active-low load strobe, sampled on the clock edge
//     SC_TIMER_SEL_InBUS      channel addressed by load and by count readback
//     SC_TIMER_MODE_InHigh    mode loaded with the limit: 1=periodic, 0=one-shot
//     SC_TIMER_data_InBUS     limit value to load
//     SC_TIMER_EN_InHigh      global count enable shared by all channels
//     SC_TIMER_signal_OutLow  per-channel terminal pulse, registered, active low
//     SC_TIMER_busy_OutBUS    per-channel running flag, registered
//     SC_TIMER_count_OutBUS   count of the selected channel (combinational)
//
//   Handshake: there is no valid/ready pair. A load is a single-edge command:
//   when SC_TIMER_LOAD_InLow is 0 at a rising clock edge the addressed
//   channel takes the bus values on that edge, unconditionally, with no
//   back-pressure. Holding the strobe low reloads on every edge.
//
//   Modports
//     master  controller side (drives load bus and enable, reads status)
//     slave   timer side
// ---------------------------------------------------------------------------
interface sc_multichannel_timer_if #(
  parameter int COUNTER_DATAWIDTH = 8,
  parameter int COUNTER_CHANNELS  = 4,
  parameter int SEL_WIDTH         = 2
);
  logic                         SC_TIMER_LOAD_InLow;
  logic [SEL_WIDTH-1:0]         SC_TIMER_SEL_InBUS;
  logic                         SC_TIMER_MODE_InHigh;
  logic [COUNTER_DATAWIDTH-1:0] SC_TIMER_data_InBUS;
  logic                         SC_TIMER_EN_InHigh;
  logic [COUNTER_CHANNELS-1:0]  SC_TIMER_signal_OutLow;
  logic [COUNTER_CHANNELS-1:0]  SC_TIMER_busy_OutBUS;
  logic [COUNTER_DATAWIDTH-1:0] SC_TIMER_count_OutBUS;

  modport master (
    output SC_TIMER_LOAD_InLow,
    output SC_TIMER_SEL_InBUS,
    output SC_TIMER_MODE_InHigh,
    output SC_TIMER_data_InBUS,
    output SC_TIMER_EN_InHigh,
    input  SC_TIMER_signal_OutLow,
    input  SC_TIMER_busy_OutBUS,
    input  SC_TIMER_count_OutBUS
  );

  modport slave (
    input  SC_TIMER_LOAD_InLow,
    input  SC_TIMER_SEL_InBUS,
    input  SC_TIMER_MODE_InHigh,
    input  SC_TIMER_data_InBUS,
    input  SC_TIMER_EN_InHigh,
    output SC_TIMER_signal_OutLow,
    output SC_TIMER_busy_OutBUS,
    output SC_TIMER_count_OutBUS
  );
endinterface

// File: rtl/sc_multichannel_timer.sv
// ---------------------------------------------------------------------------
// sc_multichannel_timer
//   N independent programmable timers sharing one load bus. Each channel
//   raises a one-cycle active-low pulse every LIMIT enabled clocks, either
//   once (one-shot) or repeatedly (periodic). A global enable pauses every
//   channel without losing its count.
//
//   Parameters
//     COUNTER_DATAWIDTH  width of limit/count registers and data/count buses
//     COUNTER_CHANNELS   number of channels, 1..16
//     SEL_WIDTH          channel select width, 2**SEL_WIDTH >= COUNTER_CHANNELS
//
//   Ports
//     SC_TIMER_CLOCK_50      system clock, all state on rising edge
//     SC_TIMER_RESET_InHigh  asynchronous active-high reset
//     tmr                    load bus / enable / status (see interface file)
//
//   Per-channel state is limit, count, mode and running; the terminal pulse
//   has its own register so the output is glitch-free. The running vector
//   is the channel state and is visible directly on SC_TIMER_busy_OutBUS.
// ---------------------------------------------------------------------------
module sc_multichannel_timer #(
  parameter int COUNTER_DATAWIDTH = 8,
  parameter int COUNTER_CHANNELS  = 4,
  parameter int SEL_WIDTH         = 2
) (
  input  logic                   SC_TIMER_CLOCK_50,
  input  logic                   SC_TIMER_RESET_InHigh,
  sc_multichannel_timer_if.slave tmr
);

  localparam int W = COUNTER_DATAWIDTH;
  localparam int N = COUNTER_CHANNELS;
  localparam logic [W-1:0] ONE = W'(1);

  // Registered state
  logic [W-1:0] limit_r   [N];
  logic [W-1:0] count_r   [N];
  logic [N-1:0] mode_r;
  logic [N-1:0] running_r;
  logic [N-1:0] signal_r;

  // Next-state values
  logic [W-1:0] limit_n   [N];
  logic [W-1:0] count_n   [N];
  logic [N-1:0] mode_n;
  logic [N-1:0] running_n;
  logic [N-1:0] signal_n;

  // Decoded per-channel events
  logic [N-1:0] load_hit;
  logic [N-1:0] terminal;
  logic [W-1:0] count_mux;

  // A select value at or beyond N matches no channel, so such a load is
  // silently dropped without any extra guard.
  always_comb begin
    load_hit = '0;
    for (int c = 0; c < N; c++) begin
      load_hit[c] = !tmr.SC_TIMER_LOAD_InLow &&
                    (int'(tmr.SC_TIMER_SEL_InBUS) == c);
    end
  end

  // Terminal event: last enabled cycle of the period. limit-1 only matters
  // while running, and running is never set with limit 0, so the wrap of
  // 0-1 is harmless.
  always_comb begin
    terminal = '0;
    for (int c = 0; c < N; c++) begin
      terminal[c] = running_r[c] && tmr.SC_TIMER_EN_InHigh &&
                    (count_r[c] == (limit_r[c] - ONE));
    end
  end

  // Next-state: load has priority over a terminal event on the same channel,
  // so reloading on the terminal cycle suppresses that pulse.
  always_comb begin
    limit_n   = limit_r;
    count_n   = count_r;
    mode_n    = mode_r;
    running_n = running_r;
    signal_n  = '1;
    for (int c = 0; c < N; c++) begin
      if (load_hit[c]) begin
        limit_n[c]   = tmr.SC_TIMER_data_InBUS;
        mode_n[c]    = tmr.SC_TIMER_MODE_InHigh;
        count_n[c]   = '0;
        running_n[c] = (tmr.SC_TIMER_data_InBUS != '0);
      end else if (terminal[c]) begin
        count_n[c]  = '0;
        signal_n[c] = 1'b0;
        if (!mode_r[c]) begin
          running_n[c] = 1'b0;
        end
      end else if (running_r[c] && tmr.SC_TIMER_EN_InHigh) begin
        count_n[c] = count_r[c] + ONE;
      end
    end
  end

  always_ff @(posedge SC_TIMER_CLOCK_50 or posedge SC_TIMER_RESET_InHigh) begin
    if (SC_TIMER_RESET_InHigh) begin
      for (int c = 0; c < N; c++) begin
        limit_r[c] <= '0;
        count_r[c] <= '0;
      end
      mode_r    <= '0;
      running_r <= '0;
      signal_r  <= '1;
    end else begin
      for (int c = 0; c < N; c++) begin
        limit_r[c] <= limit_n[c];
        count_r[c] <= count_n[c];
      end
      mode_r    <= mode_n;
      running_r <= running_n;
      signal_r  <= signal_n;
    end
  end

  // Count readback: out-of-range select matches nothing and reads 0.
  always_comb begin
    count_mux = '0;
    for (int c = 0; c < N; c++) begin
      if (int'(tmr.SC_TIMER_SEL_InBUS) == c) begin
        count_mux = count_r[c];
      end
    end
  end

  assign tmr.SC_TIMER_signal_OutLow = signal_r;
  assign tmr.SC_TIMER_busy_OutBUS   = running_r;
  assign tmr.SC_TIMER_count_OutBUS  = count_mux;

endmodule

// File: tb/tb_sc_multichannel_timer.sv
module tb_sc_multichannel_timer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 3;  // wide enough to address the non-existent channel 4
  localparam int OW = 2 * N + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sc_multichannel_timer_if #(
    .COUNTER_DATAWIDTH(W), .COUNTER_CHANNELS(N), .SEL_WIDTH(S)
  ) tmr_if ();

  sc_multichannel_timer #(
    .COUNTER_DATAWIDTH(W), .COUNTER_CHANNELS(N), .SEL_WIDTH(S)
  ) dut (
    .SC_TIMER_CLOCK_50    (clk),
    .SC_TIMER_RESET_InHigh(rst),
    .tmr                  (tmr_if)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic         rst;
    logic         load_n;
    logic [S-1:0] sel;
    logic         mode;
    logic [W-1:0] data;
    logic         en;
    logic [N-1:0] sig;
    logic [N-1:0] busy;
    logic [W-1:0] cnt;
    int           test;
  } vec_t;

  vec_t          tbl[$];
  logic [OW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [OW-1:0] dut_out();
    return {tmr_if.SC_TIMER_signal_OutLow, tmr_if.SC_TIMER_busy_OutBUS,
            tmr_if.SC_TIMER_count_OutBUS};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sig=%b busy=%b cnt=%0d, expected sig=%b busy=%b cnt=%0d",
               name, act[OW-1 -: N], act[W +: N], act[W-1:0],
               exp[OW-1 -: N], exp[W +: N], exp[W-1:0]);
    end
  endtask

  task automatic drive(input logic ln, input logic [S-1:0] sel, input logic m,
                       input logic [W-1:0] d, input logic e);
    tmr_if.SC_TIMER_LOAD_InLow  = ln;
    tmr_if.SC_TIMER_SEL_InBUS   = sel;
    tmr_if.SC_TIMER_MODE_InHigh = m;
    tmr_if.SC_TIMER_data_InBUS  = d;
    tmr_if.SC_TIMER_EN_InHigh   = e;
  endtask

  // Reset pulse between edges; checks the reset state while it is held.
  task automatic do_reset(input string name);
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    check(name, dut_out(), {4'b1111, 4'b0000, 8'd0});
    #1;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, queue expected post-edge outputs, compare #1 after edge.
  task automatic step(input logic ln, input logic [S-1:0] sel, input logic m,
                      input logic [W-1:0] d, input logic e, input logic [N-1:0] sg,
                      input logic [N-1:0] bz, input logic [W-1:0] c, input string name);
    logic [OW-1:0] exp;
    drive(ln, sel, m, d, e);
    exp_q.push_back({sg, bz, c});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(name, dut_out(), exp);
  endtask

  task automatic add(input logic r, input logic ln, input logic [S-1:0] sel,
                     input logic m, input logic [W-1:0] d, input logic e,
                     input logic [N-1:0] sg, input logic [N-1:0] bz,
                     input logic [W-1:0] c, input int t);
    vec_t v;
    v.rst = r; v.load_n = ln; v.sel = sel; v.mode = m; v.data = d; v.en = e;
    v.sig = sg; v.busy = bz; v.cnt = c; v.test = t;
    tbl.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    // Test 2: ch1 LIMIT=4 periodic, pulses at edges 4, 8, 12 after load.
    add(1, 0, 1, 1, 8'd4, 1, 4'b1111, 4'b0010, 8'd0, 2);
    for (int k = 1; k <= 12; k++)
      add(0, 1, 1, 0, 8'd0, 1, (k % 4 == 0) ? 4'b1101 : 4'b1111, 4'b0010, 8'(k % 4), 2);

    // Test 3: ch2 LIMIT=3 one-shot, single pulse at edge 3 then idle.
    add(1, 0, 2, 0, 8'd3, 1, 4'b1111, 4'b0100, 8'd0, 3);
    add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0100, 8'd1, 3);
    add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0100, 8'd2, 3);
    add(0, 1, 2, 0, 8'd0, 1, 4'b1011, 4'b0000, 8'd0, 3);
    for (int k = 4; k <= 13; k++)
      add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0000, 8'd0, 3);

    // Test 4: ch0 LIMIT=6 periodic, EN low for 2 cycles at count 2 -> pulse at edge 8.
    add(1, 0, 0, 1, 8'd6, 1, 4'b1111, 4'b0001, 8'd0, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd1, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd2, 4);
    add(0, 1, 0, 0, 8'd0, 0, 4'b1111, 4'b0001, 8'd2, 4);
    add(0, 1, 0, 0, 8'd0, 0, 4'b1111, 4'b0001, 8'd2, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd3, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd4, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd5, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1110, 4'b0001, 8'd0, 4);
    add(0, 1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd1, 4);

    // Test 5: ch0 LIMIT=1 periodic, ch3 reloaded on its terminal cycle with LIMIT=2.
    add(1, 0, 0, 1, 8'd1, 1, 4'b1111, 4'b0001, 8'd0, 5);
    add(0, 0, 3, 1, 8'd3, 1, 4'b1110, 4'b1001, 8'd0, 5);
    add(0, 1, 3, 0, 8'd0, 1, 4'b1110, 4'b1001, 8'd1, 5);
    add(0, 1, 3, 0, 8'd0, 1, 4'b1110, 4'b1001, 8'd2, 5);
    add(0, 0, 3, 1, 8'd2, 1, 4'b1110, 4'b1001, 8'd0, 5);
    add(0, 1, 3, 0, 8'd0, 1, 4'b1110, 4'b1001, 8'd1, 5);
    add(0, 1, 3, 0, 8'd0, 1, 4'b0110, 4'b1001, 8'd0, 5);
    add(0, 1, 3, 0, 8'd0, 1, 4'b1110, 4'b1001, 8'd1, 5);
    add(0, 1, 3, 0, 8'd0, 1, 4'b0110, 4'b1001, 8'd0, 5);

    // Test 6: load with SEL=4 ignored; LIMIT=0 channel stays idle.
    add(1, 0, 1, 1, 8'd5, 1, 4'b1111, 4'b0010, 8'd0, 6);
    add(0, 1, 1, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd1, 6);
    add(0, 0, 4, 1, 8'd7, 1, 4'b1111, 4'b0010, 8'd0, 6);
    add(0, 1, 1, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd3, 6);
    add(0, 1, 1, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd4, 6);
    add(0, 1, 1, 0, 8'd0, 1, 4'b1101, 4'b0010, 8'd0, 6);
    add(0, 0, 2, 1, 8'd0, 1, 4'b1111, 4'b0010, 8'd0, 6);  // ch1 count now 1
    add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd0, 6);  // ch1 2
    add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd0, 6);  // ch1 3
    add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd0, 6);  // ch1 4
    add(0, 1, 2, 0, 8'd0, 1, 4'b1101, 4'b0010, 8'd0, 6);  // ch1 terminal
    add(0, 1, 2, 0, 8'd0, 1, 4'b1111, 4'b0010, 8'd0, 6);
    add(0, 1, 2, 0, 8'd0, 0, 4'b1111, 4'b0010, 8'd0, 6);

    #1;

    // Test 1 (hand sequence): asynchronous reset mid-count.
    do_reset("t1_reset_initial");
    step(0, 0, 1, 8'd5, 1, 4'b1111, 4'b0001, 8'd0, "t1_load");
    step(1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd1, "t1_cnt1");
    step(1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd2, "t1_cnt2");
    step(1, 0, 0, 8'd0, 1, 4'b1111, 4'b0001, 8'd3, "t1_cnt3");
    #1;
    rst = 1'b1;
    #1;
    check("t1_reset_midcount", dut_out(), {4'b1111, 4'b0000, 8'd0});
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++)
      step(1, 0, 0, 8'd0, 1, 4'b1111, 4'b0000, 8'd0, $sformatf("t1_idle%0d", k));

    // Table-driven tests 2..6.
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("t%0d_reset", tbl[i].test));
      step(tbl[i].load_n, tbl[i].sel, tbl[i].mode, tbl[i].data, tbl[i].en,
           tbl[i].sig, tbl[i].busy, tbl[i].cnt, $sformatf("t%0d_vec%0d", tbl[i].test, i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
